// File: rtl/commit_trace_sequencer.sv
// rtl/commit_trace_sequencer.sv - dual-lane commit record serialiser for the exit/difftest sink
//
// Purpose: accepts up to two commit records per cycle (lane 0 older than lane 1),
// buffers them in a DEPTH-entry FIFO and emits them one per cycle in program order.
// The stream stops cleanly after the first halt record has been emitted.
//
// Configuration macro: COMMIT_TRACE_ALL_EN
//   defined   - every dequeued record pulses out_commit
//   undefined - records drain and are counted, but only the halt record pulses out_commit
//
// Ports:
//   clock, reset            clock and synchronous active-high reset
//   in0_* / in1_*           lane-0 (older) and lane-1 (younger) commit records
//   in_ready                both lanes are accepted this cycle when high
//   out_commit              one-cycle pulse, out_* carry a record
//   out_pc/addr/mem/ret/halt emitted record fields (held between pulses)
//   halted                  stream stopped after halt record emitted
//   retire_cnt              records dequeued since reset (wraps)

module commit_trace_sequencer #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in0_valid,
  input  logic [XLEN-1:0] in0_pc,
  input  logic [XLEN-1:0] in0_addr,
  input  logic            in0_mem,
  input  logic            in0_ret,
  input  logic            in0_halt,
  input  logic            in1_valid,
  input  logic [XLEN-1:0] in1_pc,
  input  logic [XLEN-1:0] in1_addr,
  input  logic            in1_mem,
  input  logic            in1_ret,
  input  logic            in1_halt,
  output logic            in_ready,
  output logic            out_commit,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_addr,
  output logic            out_mem,
  output logic            out_ret,
  output logic            out_halt,
  output logic            halted,
  output logic [31:0]     retire_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 2 * XLEN + 3;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW:0] TWO_C   = (AW + 1)'(2);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_STOP   = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0]    state_q;
  logic [EW-1:0] fifo_q [DEPTH];
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW:0]   count_q;

  logic [EW-1:0] rec0;
  logic [EW-1:0] rec1;
  logic [EW-1:0] head;
  logic          take0;
  logic          take1;
  logic [1:0]    push_cnt;
  logic          pop;
  logic          emit;
  logic          halt_in;
  logic [AW:0]   free_slots;

  assign rec0 = {in0_pc, in0_addr, in0_mem, in0_ret, in0_halt};
  assign rec1 = {in1_pc, in1_addr, in1_mem, in1_ret, in1_halt};
  assign head = fifo_q[rd_ptr_q];

  // Readiness looks only at the registered count so a pop in the same cycle
  // never opens extra room; two free slots always cover a full dual push.
  assign free_slots = DEPTH_C - count_q;
  assign in_ready   = !reset && (state_q == ST_RUN) && (free_slots >= TWO_C);

  // A lane-1 record younger than an accepted lane-0 halt is dropped.
  assign take0    = in_ready && in0_valid;
  assign take1    = in_ready && in1_valid && !(take0 && in0_halt);
  assign push_cnt = {1'b0, take0} + {1'b0, take1};
  assign halt_in  = (take0 && in0_halt) || (take1 && in1_halt);

  assign pop = (count_q != '0) && (state_q != ST_HALTED);

`ifdef COMMIT_TRACE_ALL_EN
  assign emit = pop;
`else
  assign emit = pop && head[0];
`endif

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (take0) fifo_q[wr_ptr_q] <= rec0;
    if (take1) fifo_q[wr_ptr_q + AW'(take0)] <= rec1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_RUN;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      out_commit <= 1'b0;
      out_pc     <= '0;
      out_addr   <= '0;
      out_mem    <= 1'b0;
      out_ret    <= 1'b0;
      out_halt   <= 1'b0;
      halted     <= 1'b0;
      retire_cnt <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(push_cnt);
      count_q  <= count_q + (AW + 1)'(push_cnt) - (AW + 1)'(pop);
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + AW'(1);
        retire_cnt <= retire_cnt + 32'd1;
      end

      out_commit <= emit;
      if (emit) begin
        {out_pc, out_addr, out_mem, out_ret, out_halt} <= head;
      end

      // Halt dequeue wins over any transition: the stream is finished.
      if (pop && head[0]) begin
        state_q <= ST_HALTED;
      end else if (halt_in) begin
        state_q <= ST_STOP;
      end

      // Lags the HALTED state by one cycle so it rises after the out_halt pulse.
      halted <= (state_q == ST_HALTED);
    end
  end

endmodule
